pipo: RTL and testbench

PIPO -- requirements
Module: pipo

---
 rtl/pipo.sv | 32 +++
 tb/tb_pipo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipo.sv
// Parallel-in, parallel-out register: DEPTH cascaded stages of bits-wide flops.
// Reset is asynchronous active-low and loads RESET_VAL into every stage.
module pipo #(
  parameter int              bits      = 8,
  parameter int              DEPTH     = 1,
  parameter logic [bits-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] d_in,
  output logic [bits-1:0] q
);

  if (bits < 1 || DEPTH < 1 || DEPTH > 16) begin : g_param_check
    $error("pipo: bits must be >= 1 and DEPTH must be within 1..16");
  end

  logic [bits-1:0] data_p [DEPTH];

  // Stage 0 captures d_in; every later stage shifts from its predecessor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) data_p[k] <= RESET_VAL;
    end else begin
      data_p[0] <= d_in;
      for (int k = 1; k < DEPTH; k++) data_p[k] <= data_p[k-1];
    end
  end

  assign q = data_p[DEPTH-1];

endmodule

// File: tb/tb_pipo.sv
// Scoreboarded bench for pipo across several widths, depths and reset values.
module tb_pipo;

  localparam int NI = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] din [NI];
  logic [7:0]  d1, d3, dr, d16, q1, q3, qr, q16;
  logic        db, qb;
  logic [31:0] d32, q32;

  assign d1  = din[0][7:0];
  assign d3  = din[1][7:0];
  assign dr  = din[2][7:0];
  assign db  = din[3][0];
  assign d32 = din[4];
  assign d16 = din[5][7:0];

  pipo #(.bits(8),  .DEPTH(1))                       u1  (.clk(clk), .rst(rst), .d_in(d1),  .q(q1));
  pipo #(.bits(8),  .DEPTH(3))                       u3  (.clk(clk), .rst(rst), .d_in(d3),  .q(q3));
  pipo #(.bits(8),  .DEPTH(1), .RESET_VAL(8'h3C))    ur  (.clk(clk), .rst(rst), .d_in(dr),  .q(qr));
  pipo #(.bits(1),  .DEPTH(1))                       ub  (.clk(clk), .rst(rst), .d_in(db),  .q(qb));
  pipo #(.bits(32), .DEPTH(1))                       u32 (.clk(clk), .rst(rst), .d_in(d32), .q(q32));
  pipo #(.bits(8),  .DEPTH(16))                      u16 (.clk(clk), .rst(rst), .d_in(d16), .q(q16));

  // Reference: q equals the input sampled DEPTH edges ago, or the reset value
  // while fewer than DEPTH running edges have elapsed since reset.
  int          dep  [NI] = '{1, 3, 1, 1, 1, 16};
  logic [31:0] rv   [NI] = '{32'h0, 32'h0, 32'h3C, 32'h0, 32'h0, 32'h0};
  logic [31:0] mask [NI] = '{32'hFF, 32'hFF, 32'hFF, 32'h1, 32'hFFFF_FFFF, 32'hFF};
  string       nm   [NI] = '{"w8d1", "w8d3", "w8rv3c", "w1d1", "w32d1", "w8d16"};

  logic [31:0] samp [NI][0:1023];
  int          since [NI];
  int          ecnt = 0;

  typedef struct {
    int          id;
    logic [31:0] val;
  } exp_t;
  exp_t sbq [$];

  int compared = 0;
  int failed   = 0;

  function automatic logic [31:0] get_q(input int id);
    case (id)
      0:       return {24'h0, q1};
      1:       return {24'h0, q3};
      2:       return {24'h0, qr};
      3:       return {31'h0, qb};
      4:       return q32;
      default: return {24'h0, q16};
    endcase
  endfunction

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h, expected %h at %0t", n, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents a new output every cycle; compare at the falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      act = get_q(e.id);
      compared++;
      if (act !== e.val) begin
        failed++;
        $display("FAIL sb_%s: got %h, expected %h at %0t", nm[e.id], act, e.val, $time);
      end
    end
  end

  // One rising edge: update the reference and queue expectations; return mid-cycle.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (!rst) begin
        since[i] = 0;
      end else begin
        samp[i][ecnt] = din[i] & mask[i];
        since[i]++;
      end
      e.id  = i;
      e.val = (since[i] >= dep[i]) ? samp[i][ecnt - dep[i] + 1] : rv[i];
      sbq.push_back(e);
    end
    ecnt++;
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_all(input string tag);
    for (int i = 0; i < NI; i++) check({tag, "_", nm[i]}, get_q(i), rv[i]);
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int i = 0; i < NI; i++) din[i] = v & mask[i];
  endtask

  initial begin
    for (int i = 0; i < NI; i++) since[i] = 0;
    set_all(32'hFFFF_FFFF);

    // Held in reset with all-ones input: outputs stay at reset value.
    repeat (3) tick();
    check_reset_all("hold_rst");

    // Release mid-cycle; a change between edges must not reach q early.
    rst = 1'b1;
    set_all(32'h0);
    #2;
    din[0] = 32'd25;
    din[1] = 32'h01;
    #1;
    check("between_edges", {24'h0, q1}, 32'h0);
    tick();
    check("capture_25", {24'h0, q1}, 32'h19);
    check("rv3c_release", {24'h0, qr}, 32'h0);
    din[1] = 32'h02;
    tick();
    din[1] = 32'h03;
    tick();
    check("depth3_first", {24'h0, q3}, 32'h01);
    din[1] = 32'h00;
    tick();
    tick();

    // Walking ones across all widths.
    for (int i = 0; i < 32; i++) begin
      din[0] = 32'h1 << (i % 8);
      din[1] = 32'h1 << ((i + 3) % 8);
      din[2] = 32'h80 >> (i % 8);
      din[3] = 32'(i % 2 == 0);
      din[4] = 32'h1 << i;
      din[5] = 32'h1 << ((i + 5) % 8);
      tick();
    end

    // Settle A5 then assert reset mid-cycle: must clear without a clock edge.
    set_all(32'hA5);
    tick();
    tick();
    check("a5_settled", {24'h0, q1}, 32'hA5);
    #1;
    rst = 1'b0;
    #1;
    check_reset_all("async_rst");
    tick();
    rst = 1'b1;

    // Randomized traffic with occasional mid-cycle resets, including mid-fill.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NI; i++) din[i] = $urandom() & mask[i];
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b0;
        #1;
        check_reset_all("rand_rst");
        repeat ($urandom_range(1, 2)) tick();
        rst = 1'b1;
      end
      tick();
    end

    @(negedge clk);
    #1;
    check("sb_drained", 32'(sbq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
